// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with a start/busy/done handshake.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic a0, b0, d_bit, br_nxt;
  logic ready, accept, last;

  always_comb begin
    a0     = a_q[0];
    b0     = b_q[0];
    d_bit  = a0 ^ b0 ^ br_q;
    br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    last   = (cnt_q == CW'(WIDTH - 1));
    ready  = (state_q == S_IDLE)
           | (state_q == S_DONE);
    accept = ready & start;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      accept: begin
        state_d = S_SHIFT;
        a_d     = a;
        b_d     = b;
        br_d    = bin;
        cnt_d   = '0;
      end
      (state_q == S_SHIFT): begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        acc_d = {d_bit, acc_q[WIDTH-1:1]};
        br_d  = br_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          // br_q is the borrow into the MSB on this step
          state_d = S_DONE;
          diff_d  = {d_bit, acc_q[WIDTH-1:1]};
          bout_d  = br_nxt;
          ovf_d   = br_q ^ br_nxt;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: directed cases, reset abort and
// a randomized sweep against an arithmetic reference.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         bout, ovf;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] prev_d;
  logic         prev_b, prev_o;

  serial_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views
  task automatic model(input  logic [W-1:0] ta,
                       input  logic [W-1:0] tb,
                       input  logic         tbin,
                       output logic [W-1:0] ed,
                       output logic         eb,
                       output logic         eo);
    int r, s;
    r  = int'(ta) - int'(tb) - int'(tbin);
    s  = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
    ed = W'(r);
    eb = (r < 0);
    eo = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
  endtask

  task automatic do_op(input logic [W-1:0] ta,
                       input logic [W-1:0] tb,
                       input logic         tbin,
                       input int           inj);
    logic [W-1:0] ed;
    logic eb, eo;
    model(ta, tb, tbin, ed, eb, eo);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (i == inj) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end else begin
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        bin = 1'($urandom);
      end
      chk("busy", 32'(busy), 32'(1));
      chk("no_done", 32'(done), 32'(0));
      chk("diff_hold", 32'(diff), 32'(prev_d));
    end
    @(negedge clk);
    start = 1'b0;
    chk("done", 32'(done), 32'(1));
    chk("busy_off", 32'(busy), 32'(0));
    chk("diff", 32'(diff), 32'(ed));
    chk("bout", 32'(bout), 32'(eb));
    chk("ovf", 32'(ovf), 32'(eo));
    prev_d = ed; prev_b = eb; prev_o = eo;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    chk("diff_keep", 32'(diff), 32'(ed));
  endtask

  initial begin
    logic [W-1:0] ed;
    logic eb, eo;
    rst_n = 1'b0; start = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    prev_d = '0; prev_b = 1'b0; prev_o = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_diff", 32'(diff), 32'(0));
    chk("rst_bout", 32'(bout), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    rst_n = 1'b1;

    do_op(8'h05, 8'h03, 1'b0, -1);
    do_op(8'h03, 8'h05, 1'b0, -1);
    do_op(8'h80, 8'h01, 1'b0, -1);
    do_op(8'h7F, 8'hFF, 1'b0, -1);
    do_op(8'h00, 8'h00, 1'b1, -1);

    // start held high: back-to-back, accepted on each DONE edge
    @(negedge clk);
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 32'(1));
        chk("b2b_hold", 32'(diff), 32'(prev_d));
      end
      @(negedge clk);
      chk("b2b_done", 32'(done), 32'(1));
      chk("b2b_diff", 32'(diff), 32'(8'h0F));
      chk("b2b_bout", 32'(bout), 32'(0));
      prev_d = 8'h0F;
      if (k == 2) start = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'(0));

    // start pulse mid-operation must be ignored
    do_op(8'h05, 8'h03, 1'b0, 2);
    do_op(8'h80, 8'h01, 1'b0, W - 1);

    // asynchronous reset during SHIFT
    @(negedge clk);
    a = 8'h7F; b = 8'hFF; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_diff", 32'(diff), 32'(0));
    chk("arst_bout", 32'(bout), 32'(0));
    chk("arst_ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    prev_d = '0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'(0));
      chk("post_rst_busy", 32'(busy), 32'(0));
    end
    do_op(8'h03, 8'h05, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), -1);
    end
    model(8'hFF, 8'hFF, 1'b1, ed, eb, eo);
    do_op(8'hFF, 8'hFF, 1'b1, -1);
    chk("edge_bout", 32'(bout), 32'(eb));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
